// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_add.sv
// rtl/serial_adder_full_add.sv - single-bit combinational full adder cell
module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder; SERIAL_ADDER_OVF_EN adds a signed-overflow output
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_cout;

  full_add u_full_add (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // On the MSB cycle carry_q is the carry into the sign bit.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && cnt_q == LAST) ovf_d = carry_q ^ fa_cout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder at WIDTH=8
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Caller must be away from the edge; start is dropped just after the accepting edge.
  task automatic drive_start(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
    a = ai;
    b = bi;
    cin = ci;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_start(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
    @(negedge clk);
    drive_start(ai, bi, ci);
  endtask

  // Edges counted include the accepting start edge; returns at the negedge where done is high.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 1;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cycles++;
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic [W-1:0] exp_sum, input logic exp_cout);
    int edges, bc;
    pulse_start(ai, bi, ci);
    wait_done(edges, bc);
    chk({tag, "_latency"}, edges, W + 1);
    chk({tag, "_busy_cycles"}, bc, W);
    chk({tag, "_sum"}, sum, exp_sum);
    chk({tag, "_cout"}, cout, exp_cout);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_sum_held"}, sum, exp_sum);
  endtask

  initial begin
    int edges, bc, dcount, last_done;
    logic [W-1:0] ra [3];
    logic [W-1:0] rb [3];
    logic         rc [3];
    logic [W:0]   model;

    #2 rst = 1'b1;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start_busy", busy, 0);

    run_op("add_35_0a", 8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0);
    run_op("add_ff_00_c1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_ff_00_c1", ovf, 0);
`endif
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_7f_01", ovf, 1);
`endif
    run_op("add_c8_64", 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_c8_64", ovf, 0);
`endif
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_80_80", ovf, 1);
`endif

    // Operands and start disturbed mid-run must not alter the result or queue a second op.
    pulse_start(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    drive_start(8'hFF, 8'hFF, 1'b1);
    wait_done(edges, bc);
    chk("midrun_sum", sum, 8'h46);
    chk("midrun_cout", cout, 0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("midrun_no_extra_op", dcount, 0);

    // Reset after four RUN edges: previous sum is half shifted and carry is 1 here.
    pulse_start(8'h0F, 8'h01, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_start(8'h0F, 8'h01, 1'b0);
    wait_done(edges, bc);
    chk("postrst_latency", edges, W + 1);
    chk("postrst_sum", sum, 8'h10);
    chk("postrst_cout", cout, 0);

    // Start held high: three back-to-back operations.
    for (int k = 0; k < 3; k++) begin
      ra[k] = W'($urandom_range(0, 255));
      rb[k] = W'($urandom_range(0, 255));
      rc[k] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    a = ra[0];
    b = rb[0];
    cin = rc[0];
    start = 1'b1;
    last_done = 0;
    for (int k = 0; k < 3; k++) begin
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) begin
          dcount = 1;
          break;
        end
      end
      chk($sformatf("b2b%0d_done_seen", k), dcount, 1);
      model = {1'b0, ra[k]} + {1'b0, rb[k]} + {{W{1'b0}}, rc[k]};
      chk($sformatf("b2b%0d_sum", k), sum, model[W-1:0]);
      chk($sformatf("b2b%0d_cout", k), cout, model[W]);
      if (k > 0) chk($sformatf("b2b%0d_period", k), cyc - last_done, W + 2);
      last_done = cyc;
      if (k < 2) begin
        a = ra[k+1];
        b = rb[k+1];
        cin = rc[k+1];
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    chk("b2b_stopped", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
